neuron_group_sequencer: RTL and testbench
=========================================

// Module: neuron_group_sequencer
// PURPOSE
//  Parametrised, sequential successor to the combinational neuron group selector.
//  Walks a range of neuron groups once per time step. For each group it:
//   - takes one group of stored potentials from memory and writes it into the neuron array (one-hot input enable);
//   - captures that group's updated potentials;
//   - hands them back to memory over a valid/ready handshake.
//  Sits between the neuron array and the potential memory controller.
// PARAMETERS
//  N_GROUPS   64  neuron groups in the array
//  GRP_N      16  neurons per group
//  POT_W      8   bits per neuron potential
//  IDX_W      6   group index width, = clog2(N_GROUPS)
//  (derived) GW = GRP_N*POT_W group bus width; AW = N_GROUPS*GW array bus width
// PORTS
//  clk                 in   1      clock, all logic on rising edge
//  rst                 in   1      synchronous reset, active high
//  start               in   1      begin sweep (sampled only in IDLE)
//  abort               in   1      cancel sweep, return to IDLE
//  grp_first           in   IDX_W  first group of sweep (sampled on start)
//  grp_last            in   IDX_W  last group of sweep (sampled on start)
//  busy                out  1      high while not IDLE
//  done                out  1      one-cycle pulse after last group handed off
//  grp_idx             out  IDX_W  group currently processed
//  pin_data            in   GW     stored potentials for grp_idx, from memory
//  pin_valid           in   1      pin_data valid
//  pin_ready           out  1      block accepts pin_data
//  potential_in_all    out  AW     write data to neuron array
//  potential_in_ien_all out N_GROUPS*GRP_N  per-neuron write enable
//  potential_out_all   in   AW     updated potentials from neuron array
//  pout_data           out  GW     captured potentials of grp_idx, to memory
//  pout_valid          out  1      pout_data valid
//  pout_ready          in   1      memory accepts pout_data
// BEHAVIOUR
//  Reset values: all outputs 0; state IDLE; grp_idx = 0.
//  FSM states: IDLE -> LOAD -> WRITE -> EMIT -> (LOAD | FIN) -> IDLE.
//  IDLE
//   - start=1: latch first/last; grp_idx <= grp_first; go to LOAD.
//   - If grp_last < grp_first, the sweep covers grp_first only (no wrap).
//  LOAD
//   - pin_ready = 1.
//   - On pin_valid & pin_ready: register pin_data into slice grp_idx of potential_in_all; go to WRITE.
//  WRITE (exactly 1 cycle)
//   - ien bits [grp_idx*GRP_N +: GRP_N] = all ones; every other ien bit = 0.
//   - Slice grp_idx of potential_in_all holds the data; all other slices = 0 (never X).
//   - At the end of WRITE, sample potential_out_all slice grp_idx into pout_data; go to EMIT.
//  EMIT
//   - pout_valid = 1; pout_data held stable until pout_ready.
//   - On handshake: if grp_idx == effective last, go to FIN; otherwise grp_idx += 1 and go to LOAD.
//  FIN (1 cycle): done = 1; then IDLE.
//  busy = (state != IDLE).
//  grp_idx holds its last value in IDLE until the next start.
//  Latency per group = 1 (LOAD accept) + 1 (WRITE) + 1 (EMIT, ready high) = 3 cycles minimum.
//  Valid/ready rules:
//   - Handshake completes on a cycle with valid & ready both high.
//   - pout_valid, once raised, is not dropped before handshake except by abort/rst.
//   - pin_ready is combinational from state only.
//  ien is a pulse: never high outside WRITE; never more than one group enabled at once.
//  abort (any non-IDLE state)
//   - Next state IDLE; ien, pout_valid, pin_ready deassert the following cycle; done is not pulsed.
//   - abort in IDLE: no effect.
//   - abort and start in the same cycle in IDLE: start wins.
//  start while busy: ignored.
//  rst has priority over abort and start; rst mid-sweep returns all outputs to their reset values next cycle.
//  grp_first/grp_last >= N_GROUPS: clamp to N_GROUPS-1.
// TESTING
//  T1 reset: assert rst 2 cycles mid-EMIT -> busy=0, pout_valid=0, ien=0, grp_idx=0.
//  T2 full sweep 0..63, pin_valid and pout_ready tied 1:
//     -> 64 single-cycle ien pulses, each on group k in order; done at cycle 193 after start; busy high 193 cycles.
//  T3 single group 5, pin_data=0x0102..10:
//     -> ien bits [80:95] high for 1 cycle; potential_in_all slice 5 = pin_data, other slices 0;
//        pout_data = model array output for slice 5.
//  T4 backpressure, grp 2..3, pout_ready low 4 cycles:
//     -> pout_valid and pout_data stable throughout; grp_idx stays 2; advances only after ready.
//  T5 grp_first=10, grp_last=4 -> only group 10 processed; one done pulse.
//  T6 abort asserted in WRITE of group 7 -> next cycle IDLE, ien=0, no done;
//     a new start afterwards runs normally from grp_first.

Source files
------------

// File: rtl/neuron_group_sequencer.sv
// Sequential neuron group sequencer: once per time step it walks a range of groups,
// loading stored potentials into the array and returning the updated ones to memory.
module neuron_group_sequencer #(
    parameter int N_GROUPS = 64,
    parameter int GRP_N    = 16,
    parameter int POT_W    = 8,
    parameter int IDX_W    = 6,
    localparam int GW      = GRP_N * POT_W,
    localparam int AW      = N_GROUPS * GW
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic [IDX_W-1:0]          grp_first,
    input  logic [IDX_W-1:0]          grp_last,
    output logic                      busy,
    output logic                      done,
    output logic [IDX_W-1:0]          grp_idx,
    input  logic [GW-1:0]             pin_data,
    input  logic                      pin_valid,
    output logic                      pin_ready,
    output logic [AW-1:0]             potential_in_all,
    output logic [N_GROUPS*GRP_N-1:0] potential_in_ien_all,
    input  logic [AW-1:0]             potential_out_all,
    output logic [GW-1:0]             pout_data,
    output logic                      pout_valid,
    input  logic                      pout_ready
);

    typedef enum logic [2:0] {IDLE, LOAD, WRITE, EMIT, FIN} state_t;

    state_t           state_r;
    logic [IDX_W-1:0] last_r;
    logic [IDX_W-1:0] first_s;
    logic [IDX_W-1:0] last_s;

    function automatic logic [IDX_W-1:0] clamp_idx(input logic [IDX_W-1:0] idx);
        if (int'(idx) >= N_GROUPS) begin
            clamp_idx = IDX_W'(N_GROUPS - 1);
        end else begin
            clamp_idx = idx;
        end
    endfunction

    assign first_s   = clamp_idx(grp_first);
    assign last_s    = clamp_idx(grp_last);
    assign busy      = (state_r != IDLE);
    assign pin_ready = (state_r == LOAD);

    // Sweep FSM; all data/enable outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r              <= IDLE;
            last_r               <= '0;
            grp_idx              <= '0;
            done                 <= 1'b0;
            pout_valid           <= 1'b0;
            pout_data            <= '0;
            potential_in_all     <= '0;
            potential_in_ien_all <= '0;
        end else if (abort && (state_r != IDLE)) begin
            state_r              <= IDLE;
            done                 <= 1'b0;
            pout_valid           <= 1'b0;
            potential_in_all     <= '0;
            potential_in_ien_all <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        grp_idx <= first_s;
                        // A reversed range degenerates to the first group only.
                        last_r  <= (last_s < first_s) ? first_s : last_s;
                        state_r <= LOAD;
                    end
                end
                LOAD: begin
                    if (pin_valid) begin
                        potential_in_all                     <= '0;
                        potential_in_all[grp_idx*GW +: GW]   <= pin_data;
                        potential_in_ien_all                 <= '0;
                        potential_in_ien_all[grp_idx*GRP_N +: GRP_N] <= '1;
                        state_r                              <= WRITE;
                    end
                end
                WRITE: begin
                    pout_data            <= potential_out_all[grp_idx*GW +: GW];
                    pout_valid           <= 1'b1;
                    potential_in_all     <= '0;
                    potential_in_ien_all <= '0;
                    state_r              <= EMIT;
                end
                EMIT: begin
                    if (pout_ready) begin
                        pout_valid <= 1'b0;
                        if (grp_idx == last_r) begin
                            done    <= 1'b1;
                            state_r <= FIN;
                        end else begin
                            grp_idx <= grp_idx + IDX_W'(1);
                            state_r <= LOAD;
                        end
                    end
                end
                FIN: begin
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_group_sequencer.sv
// Randomised bench for neuron_group_sequencer: a memory/array model drives the DUT,
// a negedge monitor compares against a group-list reference of each sweep.
module tb_neuron_group_sequencer;

    localparam int N_GROUPS = 64;
    localparam int GRP_N    = 16;
    localparam int POT_W    = 8;
    localparam int IDX_W    = 6;
    localparam int GW       = GRP_N * POT_W;
    localparam int AW       = N_GROUPS * GW;
    localparam int NN       = N_GROUPS * GRP_N;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, start, abort;
    logic [IDX_W-1:0] grp_first, grp_last, grp_idx;
    logic             busy, done;
    logic [GW-1:0]    pin_data, pout_data;
    logic             pin_valid, pin_ready, pout_valid, pout_ready;
    logic [AW-1:0]    potential_in_all, potential_out_all, noise;
    logic [NN-1:0]    potential_in_ien_all;

    neuron_group_sequencer #(
        .N_GROUPS(N_GROUPS), .GRP_N(GRP_N), .POT_W(POT_W), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .grp_first(grp_first), .grp_last(grp_last),
        .busy(busy), .done(done), .grp_idx(grp_idx),
        .pin_data(pin_data), .pin_valid(pin_valid), .pin_ready(pin_ready),
        .potential_in_all(potential_in_all), .potential_in_ien_all(potential_in_ien_all),
        .potential_out_all(potential_out_all),
        .pout_data(pout_data), .pout_valid(pout_valid), .pout_ready(pout_ready)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference state
    int          grp_q[$];
    logic [GW-1:0] last_pin, exp_out, prev_data, fixed_data;
    logic [IDX_W-1:0] prev_grp;
    logic        pin_hs_prev = 1'b0, stall_prev = 1'b0, monitor_on = 1'b0, fixed_en = 1'b0;
    int          busy_cnt, done_cnt, ien_cnt, stall_pct = 0, rdy_block = 0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [GW-1:0] plus_one(input logic [GW-1:0] d);
        for (int i = 0; i < GRP_N; i++) plus_one[i*POT_W +: POT_W] = d[i*POT_W +: POT_W] + 8'd1;
    endfunction

    // Neuron array model: enabled neurons present written value + 1, others show noise.
    always_comb begin
        potential_out_all = noise;
        for (int i = 0; i < NN; i++)
            if (potential_in_ien_all[i])
                potential_out_all[i*POT_W +: POT_W] = potential_in_all[i*POT_W +: POT_W] + 8'd1;
    end

    always @(negedge clk) begin
        if (monitor_on) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                chk("done_all_handed", grp_q.size(), 0);
            end
            chk("ien_only_after_load", potential_in_ien_all != '0, pin_hs_prev);
            if (potential_in_ien_all != '0) begin
                ien_cnt++;
                if (grp_q.size() > 0) begin
                    chk("ien_count", $countones(potential_in_ien_all), GRP_N);
                    chk("ien_slice", potential_in_ien_all[grp_q[0]*GRP_N +: GRP_N], 16'hFFFF);
                    chk("write_grp", grp_idx, grp_q[0]);
                    chk("pin_slice", potential_in_all[grp_q[0]*GW +: GW], last_pin);
                    chk("pin_other_zero", $countones(potential_in_all)
                        - $countones(potential_in_all[grp_q[0]*GW +: GW]), 0);
                end
                exp_out = plus_one(last_pin);
            end
            if (stall_prev) begin
                chk("pout_valid_held", pout_valid, 1'b1);
                chk("pout_data_held", pout_data, prev_data);
                chk("grp_held", grp_idx, prev_grp);
            end
            if (pout_valid && pout_ready && !rst && !abort) begin
                if (grp_q.size() == 0) begin
                    chk("pout_unexpected", 1'b1, 1'b0);
                end else begin
                    chk("pout_data", pout_data, exp_out);
                    chk("pout_grp", grp_idx, grp_q[0]);
                    void'(grp_q.pop_front());
                end
            end
            pin_hs_prev = pin_valid && pin_ready && !rst && !abort;
            if (pin_hs_prev) last_pin = pin_data;
            stall_prev = pout_valid && !pout_ready && !rst && !abort;
            prev_data  = pout_data;
            prev_grp   = grp_idx;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        pin_valid  = ($urandom_range(0, 99) >= stall_pct);
        pout_ready = ($urandom_range(0, 99) >= stall_pct);
        if (rdy_block > 0 && pout_valid) begin
            pout_ready = 1'b0;
            rdy_block--;
        end
        for (int w = 0; w < GW / 32; w++) pin_data[w*32 +: 32] = $urandom();
        if (fixed_en) pin_data = fixed_data;
        for (int w = 0; w < AW / 32; w++) noise[w*32 +: 32] = $urandom();
    endtask

    task automatic build_q(input int first, input int last, output int n);
        int eff;
        eff = (last < first) ? first : last;
        grp_q.delete();
        for (int g = first; g <= eff; g++) grp_q.push_back(g);
        n = eff - first + 1;
    endtask

    task automatic run_sweep(input int first, input int last, input int stall,
                             input int extra, input logic abort_start);
        int n, eff;
        eff = (last < first) ? first : last;
        build_q(first, last, n);
        busy_cnt = 0; done_cnt = 0; ien_cnt = 0; stall_pct = stall;
        grp_first = IDX_W'(first); grp_last = IDX_W'(last);
        start = 1'b1; abort = abort_start;
        step();
        start = 1'b0; abort = 1'b0;
        grp_first = IDX_W'($urandom); grp_last = IDX_W'($urandom);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 600 && done_cnt == 0; c++) step();
        chk("done_seen", done_cnt != 0, 1'b1);
        step();
        step();
        chk("done_once", done_cnt, 1);
        chk("idle_after", busy, 1'b0);
        chk("groups_left", grp_q.size(), 0);
        chk("ien_pulses", ien_cnt, n);
        chk("grp_idx_holds", grp_idx, eff);
        if (extra >= 0) chk("busy_cycles", busy_cnt, 3 * n + 1 + extra);
        stall_pct = 0;
    endtask

    initial begin
        int n;
        logic found;
        rst = 1'b1; start = 1'b0; abort = 1'b0; grp_first = '0; grp_last = '0;
        pin_valid = 1'b0; pout_ready = 1'b0; pin_data = '0; noise = '0;
        fixed_data = 128'h0102030405060708090a0b0c0d0e0f10;
        repeat (3) step();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_grp", grp_idx, 0);
        chk("rst_pout_valid", pout_valid, 1'b0);
        chk("rst_pin_ready", pin_ready, 1'b0);
        chk("rst_ien", $countones(potential_in_ien_all), 0);
        chk("rst_pin_all", $countones(potential_in_all), 0);
        chk("rst_pout_data", pout_data, 0);
        rst = 1'b0;
        monitor_on = 1'b1;

        // Reset while stalled in EMIT
        build_q(3, 6, n);
        rdy_block = 1000;
        grp_first = 6'd3; grp_last = 6'd6; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 20 && !pout_valid; c++) step();
        chk("t1_in_emit", pout_valid, 1'b1);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("t1_busy", busy, 1'b0);
        chk("t1_pout_valid", pout_valid, 1'b0);
        chk("t1_ien", $countones(potential_in_ien_all), 0);
        chk("t1_grp", grp_idx, 0);
        rdy_block = 0;
        grp_q.delete();
        step();

        run_sweep(0, 63, 0, 0, 1'b0);       // full sweep, 193 busy cycles
        fixed_en = 1'b1;
        run_sweep(5, 5, 0, 0, 1'b0);        // single group, fixed data
        fixed_en = 1'b0;
        rdy_block = 4;
        run_sweep(2, 3, 0, 4, 1'b0);        // backpressure
        run_sweep(10, 4, 0, 0, 1'b0);       // reversed range
        run_sweep(20, 22, 0, 0, 1'b1);      // abort with start: start wins

        // Abort in WRITE of group 7
        build_q(7, 9, n);
        done_cnt = 0;
        grp_first = 6'd7; grp_last = 6'd9; start = 1'b1;
        step();
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            step();
            if (potential_in_ien_all != '0) found = 1'b1;
        end
        chk("t6_in_write", found, 1'b1);
        chk("t6_grp", grp_idx, 7);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t6_busy", busy, 1'b0);
        chk("t6_ien", $countones(potential_in_ien_all), 0);
        chk("t6_pout_valid", pout_valid, 1'b0);
        chk("t6_pin_ready", pin_ready, 1'b0);
        repeat (3) step();
        chk("t6_no_done", done_cnt, 0);
        grp_q.delete();
        run_sweep(7, 9, 0, 0, 1'b0);

        for (int k = 0; k < 6; k++) begin
            int f, l;
            f = $urandom_range(0, 63);
            l = (k % 3 == 2) ? $urandom_range(0, 63) : f + $urandom_range(0, 8);
            if (l > 63) l = 63;
            run_sweep(f, l, 30, -1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
